tcp_rx_ctrl: RTL and testbench

- Control FSM that sequences the TCP receive datapath one packet at a time.
- Accepts a parsed packet and drives the datapath save strobes (input / flow state / calcs, flowid source select).
- Per packet, takes one of three paths:
  - established flow (fastpath): flow-CAM lookup → state reads → calc → state writeback plus scheduler update.
  - new flow (SYN miss): flowid allocation → new-flow state/CAM install → app notify → SYN-ACK enqueue.
  - drop.

---
 rtl/tcp_pkg.sv | 24 ++
 rtl/tcp_rx_ctrl_multi_done.sv | 31 +++
 rtl/tcp_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tcp_rx_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP receive control path.
package tcp_pkg;

    localparam int unsigned DROP_CNT_W_DEFAULT = 16;
    localparam int unsigned TCP_FLAGS_W        = 8;

    // Bit positions inside the 8-bit TCP flags field
    localparam int unsigned TCP_FLAG_SYN = 1;
    localparam int unsigned TCP_FLAG_ACK = 4;

    typedef enum logic [3:0] {
        RX_IDLE,
        RX_CAM_REQ,
        RX_CAM_RESP,
        RX_RD_REQ,
        RX_RD_RESP,
        RX_CALC,
        RX_UPDATE,
        RX_FLOWID,
        RX_NEW_FLOW,
        RX_DROP
    } tcp_rx_ctrl_state_e;

endpackage

// File: rtl/tcp_rx_ctrl_multi_done.sv
// N-way request fan-out: each val stays up until its own handshake, all_done
// fires in the cycle the last outstanding handshake completes.
module tcp_rx_ctrl_multi_done #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         val_set,
    input  logic [N-1:0] rdy,
    output logic [N-1:0] val,
    output logic         all_done
);

    logic [N-1:0] done_q;
    logic [N-1:0] fire;

    assign val      = {N{val_set}} & ~done_q;
    assign fire     = val & rdy;
    assign all_done = val_set & (&(done_q | fire));

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q <= '0;
        end else if (!val_set || all_done) begin
            done_q <= '0;
        end else begin
            done_q <= done_q | fire;
        end
    end

endmodule

// File: rtl/tcp_rx_ctrl.sv
// Receive control FSM: steps one packet at a time through the fastpath,
// new-flow or drop sequence and drives the datapath strobes.
module tcp_rx_ctrl
    import tcp_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = DROP_CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_pkt_val,
    output logic                   rx_pkt_rdy,
    input  logic [TCP_FLAGS_W-1:0] rx_tcp_flags,
    output logic                   read_flow_cam_val,
    input  logic                   read_flow_cam_rdy,
    input  logic                   read_flow_cam_resp_val,
    input  logic                   read_flow_cam_hit,
    output logic                   flowid_req_val,
    input  logic                   flowid_req_rdy,
    input  logic                   flowid_avail,
    output logic                   state_rd_req_val,
    input  logic                   state_rd_req_rdy,
    input  logic                   state_rd_resp_val,
    output logic                   state_wr_req_val,
    input  logic                   state_wr_req_rdy,
    output logic                   rx_sched_update_val,
    input  logic                   rx_sched_update_rdy,
    output logic                   new_flow_val,
    input  logic                   new_flow_rdy,
    output logic                   app_new_flow_val,
    input  logic                   app_new_flow_rdy,
    output logic                   slow_path_send_pkt_enqueue_val,
    input  logic                   slow_path_send_pkt_enqueue_rdy,
    output logic                   ctrl_datap_save_input,
    output logic                   ctrl_datap_save_flow_state,
    output logic                   ctrl_datap_save_calcs,
    output logic                   store_flowid_cam,
    output logic                   store_flowid_manager,
    output logic [DROP_CNT_W-1:0]  rx_drop_cnt,
    output logic                   ctrl_busy
);

    tcp_rx_ctrl_state_e state_q, state_d;
    logic               syn_q, ack_q;
    logic               drop_inc;
    logic               upd_set, upd_all_done;
    logic               nf_set, nf_all_done;
    logic [1:0]         upd_val;
    logic [2:0]         nf_val;
    logic               unused_flags;

    // Only SYN and ACK steer the control path; other flag bits belong to the datapath
    assign unused_flags = ^rx_tcp_flags;

    assign upd_set = rst && (state_q == RX_UPDATE);
    assign nf_set  = rst && (state_q == RX_NEW_FLOW);

    tcp_rx_ctrl_multi_done #(.N(2)) u_upd_done (
        .clk      (clk),
        .rst      (rst),
        .val_set  (upd_set),
        .rdy      ({rx_sched_update_rdy, state_wr_req_rdy}),
        .val      (upd_val),
        .all_done (upd_all_done)
    );

    tcp_rx_ctrl_multi_done #(.N(3)) u_nf_done (
        .clk      (clk),
        .rst      (rst),
        .val_set  (nf_set),
        .rdy      ({slow_path_send_pkt_enqueue_rdy, app_new_flow_rdy, new_flow_rdy}),
        .val      (nf_val),
        .all_done (nf_all_done)
    );

    assign state_wr_req_val               = upd_val[0];
    assign rx_sched_update_val            = upd_val[1];
    assign new_flow_val                   = nf_val[0];
    assign app_new_flow_val               = nf_val[1];
    assign slow_path_send_pkt_enqueue_val = nf_val[2];

    assign ctrl_datap_save_input = rx_pkt_val & rx_pkt_rdy;
    assign store_flowid_manager  = flowid_req_val & flowid_req_rdy;
    assign ctrl_busy             = (state_q != RX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RX_IDLE;
            syn_q       <= 1'b0;
            ack_q       <= 1'b0;
            rx_drop_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl_datap_save_input) begin
                syn_q <= rx_tcp_flags[TCP_FLAG_SYN];
                ack_q <= rx_tcp_flags[TCP_FLAG_ACK];
            end
            if (drop_inc && (rx_drop_cnt != '1)) begin
                rx_drop_cnt <= rx_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Next-state and request decode; everything stays low while in reset
    always_comb begin
        state_d                    = state_q;
        rx_pkt_rdy                 = 1'b0;
        read_flow_cam_val          = 1'b0;
        flowid_req_val             = 1'b0;
        state_rd_req_val           = 1'b0;
        ctrl_datap_save_flow_state = 1'b0;
        ctrl_datap_save_calcs      = 1'b0;
        store_flowid_cam           = 1'b0;
        drop_inc                   = 1'b0;
        if (rst) begin
            unique case (state_q)
                RX_IDLE: begin
                    rx_pkt_rdy = 1'b1;
                    if (rx_pkt_val) state_d = RX_CAM_REQ;
                end
                RX_CAM_REQ: begin
                    read_flow_cam_val = 1'b1;
                    if (read_flow_cam_rdy) state_d = RX_CAM_RESP;
                end
                RX_CAM_RESP: begin
                    if (read_flow_cam_resp_val) begin
                        if (read_flow_cam_hit) begin
                            store_flowid_cam = 1'b1;
                            state_d          = RX_RD_REQ;
                        end else if (syn_q && !ack_q && flowid_avail) begin
                            state_d = RX_FLOWID;
                        end else begin
                            state_d = RX_DROP;
                        end
                    end
                end
                RX_RD_REQ: begin
                    state_rd_req_val = 1'b1;
                    if (state_rd_req_rdy) state_d = RX_RD_RESP;
                end
                RX_RD_RESP: begin
                    if (state_rd_resp_val) begin
                        ctrl_datap_save_flow_state = 1'b1;
                        state_d                    = RX_CALC;
                    end
                end
                RX_CALC: begin
                    ctrl_datap_save_calcs = 1'b1;
                    state_d               = RX_UPDATE;
                end
                RX_UPDATE: begin
                    if (upd_all_done) state_d = RX_IDLE;
                end
                RX_FLOWID: begin
                    flowid_req_val = 1'b1;
                    if (flowid_req_rdy)    state_d = RX_NEW_FLOW;
                    else if (!flowid_avail) state_d = RX_DROP;
                end
                RX_NEW_FLOW: begin
                    if (nf_all_done) state_d = RX_IDLE;
                end
                RX_DROP: begin
                    drop_inc = 1'b1;
                    state_d  = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Self-checking bench for tcp_rx_ctrl: peripheral responders with per-port
// delays, and a path/latency/drop-count reference model.
module tb_tcp_rx_ctrl;

    localparam int unsigned DW   = 8;
    localparam int          DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_pkt_val, rx_pkt_rdy;
    logic [7:0]    rx_tcp_flags;
    logic          read_flow_cam_val, read_flow_cam_rdy, read_flow_cam_resp_val, read_flow_cam_hit;
    logic          flowid_req_val, flowid_req_rdy, flowid_avail;
    logic          state_rd_req_val, state_rd_req_rdy, state_rd_resp_val;
    logic          state_wr_req_val, state_wr_req_rdy;
    logic          rx_sched_update_val, rx_sched_update_rdy;
    logic          new_flow_val, new_flow_rdy;
    logic          app_new_flow_val, app_new_flow_rdy;
    logic          slow_path_send_pkt_enqueue_val, slow_path_send_pkt_enqueue_rdy;
    logic          ctrl_datap_save_input, ctrl_datap_save_flow_state, ctrl_datap_save_calcs;
    logic          store_flowid_cam, store_flowid_manager;
    logic [DW-1:0] rx_drop_cnt;
    logic          ctrl_busy;

    tcp_rx_ctrl #(.DROP_CNT_W(DW)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .rx_pkt_val                     (rx_pkt_val),
        .rx_pkt_rdy                     (rx_pkt_rdy),
        .rx_tcp_flags                   (rx_tcp_flags),
        .read_flow_cam_val              (read_flow_cam_val),
        .read_flow_cam_rdy              (read_flow_cam_rdy),
        .read_flow_cam_resp_val         (read_flow_cam_resp_val),
        .read_flow_cam_hit              (read_flow_cam_hit),
        .flowid_req_val                 (flowid_req_val),
        .flowid_req_rdy                 (flowid_req_rdy),
        .flowid_avail                   (flowid_avail),
        .state_rd_req_val               (state_rd_req_val),
        .state_rd_req_rdy               (state_rd_req_rdy),
        .state_rd_resp_val              (state_rd_resp_val),
        .state_wr_req_val               (state_wr_req_val),
        .state_wr_req_rdy               (state_wr_req_rdy),
        .rx_sched_update_val            (rx_sched_update_val),
        .rx_sched_update_rdy            (rx_sched_update_rdy),
        .new_flow_val                   (new_flow_val),
        .new_flow_rdy                   (new_flow_rdy),
        .app_new_flow_val               (app_new_flow_val),
        .app_new_flow_rdy               (app_new_flow_rdy),
        .slow_path_send_pkt_enqueue_val (slow_path_send_pkt_enqueue_val),
        .slow_path_send_pkt_enqueue_rdy (slow_path_send_pkt_enqueue_rdy),
        .ctrl_datap_save_input          (ctrl_datap_save_input),
        .ctrl_datap_save_flow_state     (ctrl_datap_save_flow_state),
        .ctrl_datap_save_calcs          (ctrl_datap_save_calcs),
        .store_flowid_cam               (store_flowid_cam),
        .store_flowid_manager           (store_flowid_manager),
        .rx_drop_cnt                    (rx_drop_cnt),
        .ctrl_busy                      (ctrl_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_drops = 0;

    // Observations of the most recent packet (times relative to acceptance)
    int t_scam, t_fs, t_calc, t_upd, t_idle, t_app_hs;
    int n_si, n_cam, n_scam, n_rd, n_fs, n_calc, n_wr, n_sch, n_fid, n_sfm, n_nf, n_app, n_enq;
    int c_wr, c_sch, c_nf, c_app, c_enq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] outs_vec();
        return 32'({rx_pkt_rdy, read_flow_cam_val, flowid_req_val, state_rd_req_val,
                    state_wr_req_val, rx_sched_update_val, new_flow_val, app_new_flow_val,
                    slow_path_send_pkt_enqueue_val, ctrl_datap_save_input,
                    ctrl_datap_save_flow_state, ctrl_datap_save_calcs, store_flowid_cam,
                    store_flowid_manager, ctrl_busy});
    endfunction

    // Drives one packet through, acting as CAM, memories, flowid manager and
    // sinks, then compares everything seen against the reference model.
    task automatic run_pkt(input bit hit, input logic [7:0] flags, input bit avail,
                           input bit avail_fall, input int cam_lat, input int rd_lat,
                           input int d_wr, input int d_sch, input int d_nf, input int d_app,
                           input int d_enq, input int d_fid, input bit spur);
        int  t0, cam_at, rd_at, a_wr, a_sch, a_nf, a_app, a_enq, a_fid, exp_idle, path;
        bit  acc, done, syn, ack;
        t0 = -1; cam_at = -1; rd_at = -1; acc = 0; done = 0;
        a_wr = 0; a_sch = 0; a_nf = 0; a_app = 0; a_enq = 0; a_fid = 0;
        t_scam = -1; t_fs = -1; t_calc = -1; t_upd = -1; t_idle = -1; t_app_hs = -1;
        n_si = 0; n_cam = 0; n_scam = 0; n_rd = 0; n_fs = 0; n_calc = 0; n_wr = 0; n_sch = 0;
        n_fid = 0; n_sfm = 0; n_nf = 0; n_app = 0; n_enq = 0;
        c_wr = 0; c_sch = 0; c_nf = 0; c_app = 0; c_enq = 0;
        rx_tcp_flags = flags;
        flowid_avail = avail;
        for (int k = 0; k < 300 && !done; k++) begin
            rx_pkt_val        = !acc;
            read_flow_cam_rdy = 1'b1;
            state_rd_req_rdy  = 1'b1;
            read_flow_cam_resp_val = (k == cam_at) || (spur && cam_at < 0 && $urandom_range(0, 3) == 0);
            read_flow_cam_hit      = (k == cam_at) ? hit : 1'($urandom_range(0, 1));
            state_rd_resp_val      = (k == rd_at) || (spur && rd_at < 0 && $urandom_range(0, 3) == 0);
            if (state_wr_req_val)               a_wr++;
            if (rx_sched_update_val)            a_sch++;
            if (new_flow_val)                   a_nf++;
            if (app_new_flow_val)               a_app++;
            if (slow_path_send_pkt_enqueue_val) a_enq++;
            if (flowid_req_val)                 a_fid++;
            if (avail_fall && flowid_req_val)   flowid_avail = 1'b0;
            state_wr_req_rdy               = (a_wr > d_wr);
            rx_sched_update_rdy            = (a_sch > d_sch);
            new_flow_rdy                   = (a_nf > d_nf);
            app_new_flow_rdy               = (a_app > d_app);
            slow_path_send_pkt_enqueue_rdy = (a_enq > d_enq);
            flowid_req_rdy                 = (a_fid > d_fid) && flowid_avail;
            #1;
            if (ctrl_datap_save_input) begin
                n_si++;
                if (!acc) begin acc = 1; t0 = k; end
            end
            if (read_flow_cam_val && read_flow_cam_rdy) begin n_cam++; cam_at = k + cam_lat; end
            if (store_flowid_cam) begin n_scam++; if (t_scam < 0) t_scam = k - t0; end
            if (state_rd_req_val && state_rd_req_rdy) begin n_rd++; rd_at = k + rd_lat; end
            if (ctrl_datap_save_flow_state) begin n_fs++; if (t_fs < 0) t_fs = k - t0; end
            if (ctrl_datap_save_calcs) begin n_calc++; if (t_calc < 0) t_calc = k - t0; end
            if (state_wr_req_val) begin
                c_wr++;
                if (t_upd < 0) t_upd = k - t0;
                if (state_wr_req_rdy) n_wr++;
            end
            if (rx_sched_update_val) begin c_sch++; if (rx_sched_update_rdy) n_sch++; end
            if (new_flow_val) begin c_nf++; if (new_flow_rdy) n_nf++; end
            if (app_new_flow_val) begin
                c_app++;
                if (app_new_flow_rdy) begin n_app++; t_app_hs = k - t0; end
            end
            if (slow_path_send_pkt_enqueue_val) begin
                c_enq++;
                if (slow_path_send_pkt_enqueue_rdy) n_enq++;
            end
            if (flowid_req_val && flowid_req_rdy) n_fid++;
            if (store_flowid_manager) n_sfm++;
            if (acc && k > t0 && rx_pkt_rdy) begin done = 1; t_idle = k - t0; end
            if (!done) tick();
        end
        check("pkt_completes", 32'(done), 32'd1);

        // Reference model: path from flags/lookup, then latency by arithmetic
        syn = flags[1];
        ack = flags[4];
        if (hit) begin
            path = 0;
            exp_idle = 5 + cam_lat + rd_lat + max2(d_wr, d_sch);
        end else if (syn && !ack && avail && !avail_fall) begin
            path = 1;
            exp_idle = 4 + cam_lat + d_fid + max2(d_nf, max2(d_app, d_enq));
        end else begin
            path = 2;
            exp_idle = (syn && !ack && avail) ? 4 + cam_lat : 3 + cam_lat;
            model_drops++;
        end
        check("save_input_cnt", 32'(n_si), 32'd1);
        check("cam_req_cnt", 32'(n_cam), 32'd1);
        check("store_cam_cnt", 32'(n_scam), 32'(path == 0));
        check("rd_req_cnt", 32'(n_rd), 32'(path == 0));
        check("save_fs_cnt", 32'(n_fs), 32'(path == 0));
        check("save_calc_cnt", 32'(n_calc), 32'(path == 0));
        check("wr_cnt", 32'(n_wr), 32'(path == 0));
        check("sched_cnt", 32'(n_sch), 32'(path == 0));
        check("wr_val_cycles", 32'(c_wr), 32'(path == 0 ? d_wr + 1 : 0));
        check("sched_val_cycles", 32'(c_sch), 32'(path == 0 ? d_sch + 1 : 0));
        check("flowid_cnt", 32'(n_fid), 32'(path == 1));
        check("store_mgr_cnt", 32'(n_sfm), 32'(path == 1));
        check("new_flow_cnt", 32'(n_nf), 32'(path == 1));
        check("app_cnt", 32'(n_app), 32'(path == 1));
        check("enq_cnt", 32'(n_enq), 32'(path == 1));
        check("nf_val_cycles", 32'(c_nf), 32'(path == 1 ? d_nf + 1 : 0));
        check("app_val_cycles", 32'(c_app), 32'(path == 1 ? d_app + 1 : 0));
        check("enq_val_cycles", 32'(c_enq), 32'(path == 1 ? d_enq + 1 : 0));
        check("idle_latency", 32'(t_idle), 32'(exp_idle));
        check("drop_cnt", 32'(rx_drop_cnt), 32'(model_drops > DMAX ? DMAX : model_drops));
    endtask

    initial begin
        logic [7:0] fl;
        rst = 1'b0;
        rx_pkt_val = 0; rx_tcp_flags = 0;
        read_flow_cam_rdy = 0; read_flow_cam_resp_val = 0; read_flow_cam_hit = 0;
        flowid_req_rdy = 0; flowid_avail = 0;
        state_rd_req_rdy = 0; state_rd_resp_val = 0; state_wr_req_rdy = 0;
        rx_sched_update_rdy = 0; new_flow_rdy = 0; app_new_flow_rdy = 0;
        slow_path_send_pkt_enqueue_rdy = 0;

        // Reset: everything quiet, no acceptance while held
        rx_pkt_val = 1;
        tick(); tick(); tick();
        check("reset_outs", outs_vec(), 32'd0);
        check("reset_drop", 32'(rx_drop_cnt), 32'd0);
        rx_pkt_val = 0;
        rst = 1'b1;
        #1;
        check("post_reset_rdy", 32'(rx_pkt_rdy), 32'd1);
        check("post_reset_busy", 32'(ctrl_busy), 32'd0);

        // Fastpath with no backpressure: strobe timing
        run_pkt(1, 8'h10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lat_store_cam", 32'(t_scam), 32'd2);
        check("lat_save_fs", 32'(t_fs), 32'd4);
        check("lat_save_calc", 32'(t_calc), 32'd5);
        check("lat_update", 32'(t_upd), 32'd6);
        check("lat_idle", 32'(t_idle), 32'd7);

        // New flow with application stalling for 5 cycles
        run_pkt(0, 8'h02, 1, 0, 1, 1, 0, 0, 0, 5, 0, 0, 0);
        check("nf_idle_after_app", 32'(t_idle), 32'(t_app_hs + 1));

        // Plain ACK miss is dropped
        run_pkt(0, 8'h10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("ack_drop_cnt_one", 32'(rx_drop_cnt), 32'd1);

        // Staggered write/scheduler acceptance
        run_pkt(1, 8'h18, 1, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);

        // Simultaneous handshakes after equal delay
        run_pkt(1, 8'h10, 1, 0, 2, 2, 2, 2, 0, 0, 0, 0, 0);

        // SYN miss while the flowid pool empties during the request
        run_pkt(0, 8'h02, 1, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0:       fl = 8'h02;
                1:       fl = 8'h10;
                2:       fl = 8'h12;
                3:       fl = 8'h00;
                default: fl = 8'($urandom);
            endcase
            run_pkt(1'($urandom_range(0, 1)), fl, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 5) == 0),
                    $urandom_range(1, 3), $urandom_range(1, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1);
        end

        // Drive SYN misses with no free flowid until the counter saturates
        while (model_drops < DMAX + 3) begin
            run_pkt(0, 8'h02, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        check("drop_saturated", 32'(rx_drop_cnt), 32'(DMAX));

        // Reset while waiting for the state read response
        rx_pkt_val = 1; rx_tcp_flags = 8'h10;
        read_flow_cam_rdy = 1; state_rd_req_rdy = 1;
        read_flow_cam_resp_val = 0; state_rd_resp_val = 0;
        state_wr_req_rdy = 1; rx_sched_update_rdy = 1;
        #1;
        check("mid_accept", 32'(ctrl_datap_save_input), 32'd1);
        tick();
        rx_pkt_val = 0;
        tick();
        read_flow_cam_resp_val = 1; read_flow_cam_hit = 1;
        tick();
        read_flow_cam_resp_val = 0; read_flow_cam_hit = 0;
        #1;
        check("mid_rd_req", 32'(state_rd_req_val), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rdy_in_reset", 32'(rx_pkt_rdy), 32'd0);
        tick();
        check("mid_reset_outs", outs_vec(), 32'd0);
        check("mid_reset_drop", 32'(rx_drop_cnt), 32'd0);
        rst = 1'b1;
        model_drops = 0;
        #1;
        check("mid_release_rdy", 32'(rx_pkt_rdy), 32'd1);
        run_pkt(1, 8'h10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_pkt(0, 8'h01, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
